button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DELAY_COUNTS, default 125000 (2.5 ms at 50 MHz): consecutive stable cycles needed to accept a level change.
REQ-002 SHALL have parameter LONG_COUNTS, default 50000000 (1 s at 50 MHz): cycles in the pressed state before a long-press event.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port button, input, 1: raw, asynchronous, bouncing push-button level, active-high.
REQ-006 SHALL have port button_pressed, output, 1: debounced button level.
REQ-007 SHALL have port press_pulse, output, 1: one-cycle strobe on each accepted press; drives the downstream difficulty FSM increment input.
REQ-008 SHALL have port long_press, output, 1: one-cycle strobe when a press has been held LONG_COUNTS cycles.

Function
REQ-009 SHALL pass button through a two-flip-flop synchronizer; only the second stage (sync) feeds the FSM.
REQ-010 SHALL implement states IDLE_LOW, CHK_HIGH, HELD_HIGH, CHK_LOW.
REQ-011 SHALL, in IDLE_LOW with sync=1, move to CHK_HIGH and clear the debounce counter.
REQ-012 SHALL, in CHK_HIGH, return to IDLE_LOW if sync=0; otherwise increment, moving to HELD_HIGH on the edge after the counter equals DELAY_COUNTS-1.
REQ-013 SHALL, in HELD_HIGH with sync=0, move to CHK_LOW and clear the counter; CHK_LOW mirrors CHK_HIGH (sync=1 returns to HELD_HIGH, DELAY_COUNTS stable low cycles reach IDLE_LOW).
REQ-014 SHALL drive all outputs from registers: button_pressed=1 in HELD_HIGH and CHK_LOW, 0 otherwise.
REQ-015 SHALL assert press_pulse for exactly one cycle, on the same edge that enters HELD_HIGH from CHK_HIGH; never on CHK_LOW->HELD_HIGH.
REQ-016 SHALL make press latency exactly DELAY_COUNTS+3 rising edges from the first edge sampling button=1, when button stays high.
REQ-017 SHALL size the debounce counter $clog2(DELAY_COUNTS+1) bits; it never wraps.
REQ-018 SHALL reject DELAY_COUNTS<1 or LONG_COUNTS<1 with an elaboration-time error.
REQ-019 SHALL produce no press_pulse for any high glitch shorter than DELAY_COUNTS+1 synchronized cycles, and no release for any low glitch that short.
REQ-020 SHALL, on simultaneous counter terminal value and input reversal, honour the reversal (return to the prior stable state, no pulse).

Reset
REQ-021 SHALL, on rst=1, asynchronously clear synchronizer flops, counters and all outputs to 0 and force IDLE_LOW.
REQ-022 SHALL, when button is held across reset deassertion, treat it as a new press (press_pulse after DELAY_COUNTS+3 edges).
REQ-023 SHALL, on reset mid-debounce or mid-hold, abandon the operation with no pulse emitted.

Configuration
REQ-024 SHALL compile the long-press counter only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
REQ-025 SHALL, with the macro defined, count HELD_HIGH and CHK_LOW cycles from HELD_HIGH entry, pulse long_press once when count reaches LONG_COUNTS, saturate (no repeat), and clear on IDLE_LOW entry.
REQ-026 SHALL, without the macro, tie long_press to 0 and contain no long-press counter logic.

Structure
REQ-027 SHALL place the state enum typedef (2-bit logic) and default DELAY_COUNTS/LONG_COUNTS constants in package debounce_pkg.
REQ-028 SHALL instantiate one sub-module, sync_2ff, for the synchronizer; FSM and counters stay in button_debounce.

Verification (DELAY_COUNTS=4, LONG_COUNTS=10)
REQ-029 SHALL test a clean press: button 0->1 held 20 cycles -> press_pulse high for one cycle at edge 7, button_pressed high from edge 7.
REQ-030 SHALL test bounce: button high 3 cycles, low 1, high 20 -> exactly one press_pulse, at edge 7 after the final rise.
REQ-031 SHALL test a release glitch: held pressed, button low for 2 cycles -> button_pressed stays 1, no second press_pulse.
REQ-032 SHALL test reset: rst pulsed at edge 5 of a press -> all outputs 0 immediately; with button still high, press_pulse 7 edges after rst falls.
REQ-033 SHALL test long press with the macro defined: hold 30 cycles -> long_press once, 10 cycles after press_pulse; without the macro, long_press stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
// Contents: state_t (2-bit FSM encoding), DEFAULT_DELAY_COUNTS, DEFAULT_LONG_COUNTS.
// Defaults assume a 50 MHz clock (2.5 ms debounce, 1 s long press).
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    HELD_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  localparam int DEFAULT_DELAY_COUNTS = 125000;
  localparam int DEFAULT_LONG_COUNTS  = 50000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports: clk, rst (async active-high, clears both flops), d_i (async in), q_o (synced out).
// Latency: two rising edges from d_i change to q_o change.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes the raw level, accepts a level change only
// after DELAY_COUNTS+1 consecutive stable synchronized cycles, and emits strobes.
// Ports: clk, rst (async active-high), button (raw level), button_pressed (debounced
// level), press_pulse (1-cycle strobe per accepted press), long_press (1-cycle strobe
// after LONG_COUNTS held cycles). Press latency: DELAY_COUNTS+3 edges.
// Macro BUTTON_DEBOUNCE_LONG_PRESS_EN builds the long-press counter; otherwise
// long_press is tied low.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int DELAY_COUNTS = DEFAULT_DELAY_COUNTS,
  parameter int LONG_COUNTS  = DEFAULT_LONG_COUNTS
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic button_pressed,
  output logic press_pulse,
  output logic long_press
);

  if (DELAY_COUNTS < 1) begin : g_bad_delay
    $error("button_debounce: DELAY_COUNTS must be >= 1");
  end
  if (LONG_COUNTS < 1) begin : g_bad_long
    $error("button_debounce: LONG_COUNTS must be >= 1");
  end

  localparam int CNT_W = $clog2(DELAY_COUNTS + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DELAY_COUNTS - 1);

  logic             sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             pressed_q, pressed_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (button),
    .q_o (sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      pressed_q <= pressed_d;
    end
  end

  // The counter tops out at DELAY_COUNTS-1; the terminal edge changes state
  // instead of incrementing, so it never wraps. A reversal on the terminal
  // cycle is checked first and wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync) begin
          state_d = CHK_HIGH;
          cnt_d   = '0;
        end
      end
      CHK_HIGH: begin
        if (!sync) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_TERM) begin
          state_d = HELD_HIGH;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD_HIGH: begin
        if (!sync) begin
          state_d = CHK_LOW;
          cnt_d   = '0;
        end
      end
      CHK_LOW: begin
        if (sync) begin
          state_d = HELD_HIGH;
        end else if (cnt_q == CNT_TERM) begin
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
    // Outputs are registered from the next state so they change on the same
    // edge as the state they describe.
    pressed_d = (state_d == HELD_HIGH) || (state_d == CHK_LOW);
  end

  assign button_pressed = pressed_q;
  assign press_pulse    = press_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_COUNTS + 1);

  logic [LONG_W-1:0] lcnt_q, lcnt_d;
  logic              long_q, long_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  end

  // Counts edges spent pressed after the press edge; saturates at LONG_COUNTS
  // so the strobe fires once per press. Leaving the pressed states clears it.
  always_comb begin
    lcnt_d = lcnt_q;
    long_d = 1'b0;
    if (press_d) begin
      lcnt_d = '0;
    end else if (pressed_d) begin
      if (lcnt_q != LONG_W'(LONG_COUNTS)) begin
        lcnt_d = lcnt_q + LONG_W'(1);
        long_d = (lcnt_q == LONG_W'(LONG_COUNTS - 1));
      end
    end else begin
      lcnt_d = '0;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 10;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;
  logic button_pressed, press_pulse, long_press;

  int total = 0;
  int bad   = 0;

  button_debounce #(.DELAY_COUNTS(D), .LONG_COUNTS(L)) dut (
    .clk            (clk),
    .rst            (rst),
    .button         (button),
    .button_pressed (button_pressed),
    .press_pulse    (press_pulse),
    .long_press     (long_press)
  );

  always #5 clk = ~clk;

  // Reference model: the debounced level flips once the synchronized input has
  // disagreed with it for D+1 consecutive samples; a flip to 1 is a press.
  // Long press fires once after L further pressed edges.
  logic b1, b2, m_sync;
  logic m_lvl, m_press, m_long;
  int   m_run, m_lcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b1 = 0; b2 = 0; m_lvl = 0; m_press = 0; m_long = 0; m_run = 0; m_lcnt = 0;
    end else begin
      m_sync  = b2;
      b2      = b1;
      b1      = button;
      m_press = 0;
      m_long  = 0;
      if (m_sync != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = m_sync;
          m_run = 0;
          if (m_lvl) begin
            m_press = 1;
            m_lcnt  = 0;
          end
        end
      end else begin
        m_run = 0;
      end
      if (m_lvl && !m_press && m_lcnt < L) begin
        m_lcnt++;
        if (m_lcnt == L) m_long = 1;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge and compare all outputs to the model.
  task automatic step();
    @(posedge clk);
    #1;
    chk("pressed_vs_model", int'(button_pressed), int'(m_lvl));
    chk("pulse_vs_model", int'(press_pulse), int'(m_press));
    chk("long_vs_model", int'(long_press), LONG_EN ? int'(m_long) : 0);
  endtask

  // Run n steps, reporting (1-based) edge of first press/long strobe and counts.
  task automatic run(input int n, output int p_edge, output int p_cnt,
                     output int l_edge, output int l_cnt, output bit saw_low);
    p_edge = -1; p_cnt = 0; l_edge = -1; l_cnt = 0; saw_low = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (press_pulse) begin
        p_cnt++;
        if (p_edge < 0) p_edge = i;
      end
      if (long_press) begin
        l_cnt++;
        if (l_edge < 0) l_edge = i;
      end
      if (!button_pressed) saw_low = 1;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_pressed", int'(button_pressed), 0);
    chk("rst_pulse", int'(press_pulse), 0);
    chk("rst_long", int'(long_press), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int  pe, pc, le, lc;
  bit  sl;
  int  len;

  initial begin
    // Reset state
    #12;
    chk("reset_pressed", int'(button_pressed), 0);
    chk("reset_pulse", int'(press_pulse), 0);
    chk("reset_long", int'(long_press), 0);
    @(negedge clk);
    rst = 1'b0;
    run(10, pe, pc, le, lc, sl);
    chk("idle_no_pulse", pc, 0);

    // Clean press: strobe and level at edge D+3
    button = 1'b1;
    run(D + 2, pe, pc, le, lc, sl);
    chk("clean_early_pulse", pc, 0);
    chk("clean_not_yet_pressed", int'(button_pressed), 0);
    step();
    chk("clean_pulse_edge7", int'(press_pulse), 1);
    chk("clean_pressed_edge7", int'(button_pressed), 1);
    run(20 - (D + 3), pe, pc, le, lc, sl);
    chk("clean_single_pulse", pc, 0);
    button = 1'b0;
    run(12, pe, pc, le, lc, sl);
    chk("release_no_pulse", pc, 0);
    chk("release_level", int'(button_pressed), 0);

    // Bounce: 3 high, 1 low, 20 high
    button = 1'b1;
    run(3, pe, pc, le, lc, sl);
    chk("bounce_a_pulses", pc, 0);
    button = 1'b0;
    run(1, pe, pc, le, lc, sl);
    chk("bounce_b_pulses", pc, 0);
    button = 1'b1;
    run(20, pe, pc, le, lc, sl);
    chk("bounce_pulse_edge", pe, D + 3);
    chk("bounce_pulse_count", pc, 1);

    // Release glitch while held
    button = 1'b0;
    run(2, pe, pc, le, lc, sl);
    button = 1'b1;
    run(12, pe, pc, le, lc, sl);
    chk("glitch_stays_pressed", int'(sl), 0);
    chk("glitch_no_pulse", pc, 0);

    // Long press
    button = 1'b0;
    run(12, pe, pc, le, lc, sl);
    button = 1'b1;
    run(30, pe, pc, le, lc, sl);
    chk("long_press_edge", pe, D + 3);
    chk("long_count", lc, LONG_EN ? 1 : 0);
    chk("long_edge", le, LONG_EN ? D + 3 + L : -1);

    // Reset mid-hold
    pulse_reset();

    // Reset mid-debounce with button still high, counted from rst fall
    button = 1'b0;
    run(12, pe, pc, le, lc, sl);
    button = 1'b1;
    run(5, pe, pc, le, lc, sl);
    chk("pre_rst_no_pulse", pc, 0);
    pulse_reset();
    run(12, pe, pc, le, lc, sl);
    chk("post_rst_pulse_edge", pe, D + 3);
    chk("post_rst_pulse_count", pc, 1);

    // Randomized runs with occasional resets, checked each cycle by the model
    for (int k = 0; k < 600; k++) begin
      button = 1'($urandom_range(0, 1));
      len = (($urandom & 3) == 0) ? int'($urandom_range(D, 3 * D)) : int'($urandom_range(1, D + 2));
      run(len, pe, pc, le, lc, sl);
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end
    button = 1'b1;
    run(40, pe, pc, le, lc, sl);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
